// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one registered ALU, one op in flight
package alu_share_pkg;
  typedef struct packed {
    logic        add;
    logic        sub;
    logic        xor_;
    logic        or_;
    logic        and_;
    logic        slli;
    logic        srli;
    logic [31:0] imm;
    logic [31:0] pc;
  } control_info;
endpackage

module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ0_VALID,
  input  logic        REQ1_VALID,
  output logic        REQ0_READY,
  output logic        REQ1_READY,
  input  control_info REQ0_CTR,
  input  control_info REQ1_CTR,
  input  logic [31:0] REQ0_RS1,
  input  logic [31:0] REQ1_RS1,
  input  logic [31:0] REQ0_RS2,
  input  logic [31:0] REQ1_RS2,
  output logic        RSP0_VALID,
  output logic        RSP1_VALID,
  input  logic        RSP0_READY,
  input  logic        RSP1_READY,
  output logic [31:0] RSP0_RESULT,
  output logic [31:0] RSP1_RESULT,
  output control_info ALU_CTR,
  output logic [31:0] ALU_RS1,
  output logic [31:0] ALU_RS2,
  input  logic [31:0] ALU_RESULT
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3;
  logic [1:0]  state;
  logic        owner, last_grant, grant0, grant1;
  control_info ctr_q;
  logic [31:0] rs1_q, rs2_q, result_q;
  // requester 1 wins a tie only under round-robin when requester 0 went last
  always_comb begin
    grant1      = REQ1_VALID & (~REQ0_VALID | (~FIXED_PRIO & ~last_grant));
    grant0      = REQ0_VALID & ~grant1;
    REQ0_READY  = RSTN & (state == IDLE) & grant0;
    REQ1_READY  = RSTN & (state == IDLE) & grant1;
    RSP0_VALID  = (state == RESP) & ~owner;
    RSP1_VALID  = (state == RESP) & owner;
    RSP0_RESULT = result_q;
    RSP1_RESULT = result_q;
    ALU_CTR     = (state == EXEC) ? ctr_q : '0;
    ALU_RS1     = (state == EXEC) ? rs1_q : '0;
    ALU_RS2     = (state == EXEC) ? rs2_q : '0;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ctr_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          state      <= EXEC;
          owner      <= grant1;
          last_grant <= grant1;
          ctr_q      <= grant1 ? REQ1_CTR : REQ0_CTR;
          rs1_q      <= grant1 ? REQ1_RS1 : REQ0_RS1;
          rs2_q      <= grant1 ? REQ1_RS2 : REQ0_RS2;
        end
        EXEC: state <= CAPT;
        CAPT: begin
          state    <= RESP;
          result_q <= ALU_RESULT;
        end
        default: if (owner ? RSP1_READY : RSP0_READY) state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single registered ALU (`aluer`) between two requesters, for example the main issue stage and a secondary unit such as an address/CSR helper. It accepts one operation at a time over a valid/ready handshake and arbitrates between simultaneous requests. It drives the ALU inputs for exactly one cycle, captures the ALU's registered result, and returns it to the owning requester over a response valid/ready handshake. Only one operation is in flight at a time; while the block is idle the ALU is held at a zero operation.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 gives requester 0 strict priority.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RSTN` in 1: reset, asynchronous and active-low.
- `REQ0_VALID` / `REQ1_VALID` in 1: requester has an operation.
- `REQ0_READY` / `REQ1_READY` out 1: operation accepted on this edge if VALID is also high.
- `REQ0_CTR` / `REQ1_CTR` in `control_info`: decoded op, immediate and pc.
- `REQ0_RS1` / `REQ1_RS1`, `REQ0_RS2` / `REQ1_RS2` in 32: operand values.
- `RSP0_VALID` / `RSP1_VALID` out 1: result available for that requester.
- `RSP0_READY` / `RSP1_READY` in 1: requester takes the result.
- `RSP0_RESULT` / `RSP1_RESULT` out 32: captured result. Both are driven from the same buffer; it is meaningful only with the matching VALID.
- `ALU_CTR` out `control_info`: to the ALU's CTR_INFO input.
- `ALU_RS1` / `ALU_RS2` out 32: to the ALU's RS1_VAL and RS2_VAL inputs.
- `ALU_RESULT` in 32: from the ALU. It is registered, with one-edge latency.

## Operation
- The FSM has four states: IDLE, EXEC, CAPT, RESP. Reset state is IDLE.
- **IDLE**
  - The grant is combinational from both VALIDs and the `last_grant` register.
  - With one VALID high, that requester is granted.
  - With both high and FIXED_PRIO=1, requester 0 is granted.
  - With both high and FIXED_PRIO=0, the requester other than `last_grant` is granted.
  - REQi_READY = (state==IDLE) & grant_i. The non-granted READY is 0. READY is never high outside IDLE.
  - On handshake: latch CTR, RS1, RS2 and the owner id; set `last_grant` = owner; go to EXEC.
- **EXEC**: drive ALU_CTR/RS1/RS2 from the latch for this one cycle; go to CAPT.
- **CAPT**: ALU_RESULT now holds the op's result. At the edge, copy it into the result buffer and go to RESP.
- **RESP**
  - RSP<owner>_VALID=1; the other RSP VALID=0.
  - On RSP<owner>_READY: go to IDLE.
  - Otherwise hold the state and the buffer indefinitely. Requests stall (READY=0).
- In every state except EXEC, ALU_CTR is all-zero (every op flag and field 0) and ALU_RS1 = ALU_RS2 = 0, so the ALU computes 0.
- The block never interprets the op. Any `control_info` is passed through, including one with no flag set, which yields result 0.
- A requester may drop VALID or change its operands before its handshake. Only the values present at the handshake edge are used.
- `last_grant` updates only on an accepted handshake, never on a stall.
- Reset:
  - Asserting RSTN low in any state forces IDLE immediately. Any in-flight operation is discarded; no response is produced.
  - All outputs take their reset values while RSTN is low.
  - Reset values: REQ*_READY=0, RSP*_VALID=0, RSP*_RESULT=0, ALU_CTR=0, ALU_RS1=ALU_RS2=0, last_grant=1 (so requester 0 wins the first tie).
- Simultaneous RSP_READY and a new REQ_VALID in RESP: the response completes, and the new request is accepted no earlier than the following IDLE cycle.

## Timing
- Handshake edge E0 (REQ VALID&READY).
- Cycle after E0: EXEC; the ALU samples the operands at E1.
- Cycle after E1: CAPT; the buffer loads at E2.
- From E2 onward: RSP VALID=1.
- RSP_READY high before E3: IDLE after E3; the next handshake is possible at E4.
- Minimum issue interval is 4 cycles. Request-to-response latency is 2 edges (E0 to RSP_VALID visible after E2).
- RSP_RESULT is stable from E2 until the response handshake edge.
- REQ READY is combinational from VALID (same cycle). There is no combinational path from RSP_READY to any output except through state.

## Test plan
- **Single op, round trip.** REQ0: add, RS1=5, RS2=7, with RSP0_READY=1 → REQ0_READY=1 in IDLE; ALU_CTR shows add only in the cycle after E0; RSP0_VALID=1 after E2 with RSP0_RESULT=12; IDLE after E3. RSP1_VALID stays 0 throughout.
- **Tie arbitration, FIXED_PRIO=0.** Both requests held high continuously: REQ0 sub 10−3, REQ1 xor_ 0xF0^0x0F → grants alternate 0,1,0,1. Results are 7 on RSP0 and 0xFF on RSP1. Issue interval is 4 cycles.
- **Tie arbitration, FIXED_PRIO=1.** Both requests held high → requester 0 is granted every time; requester 1 starves.
- **Backpressure.** RSP1_READY held low for 6 cycles after RSP1_VALID rises (REQ1: slli, RS1=1, imm=4) → RSP1_RESULT stays 16, both REQ READYs stay 0, and the pending REQ0 is accepted one cycle after the RSP1 handshake.
- **Reset mid-op.** RSTN pulsed low during CAPT → all outputs at reset values immediately; no RSP VALID ever appears for that op; the next request completes normally, with requester 0 winning a tie.
- **Idle ALU drive.** Random REQ VALID toggling without handshake (no READY) → ALU_CTR/RS1/RS2 stay 0 in every non-EXEC cycle.
